// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared constants and gray/binary pointer conversions for async_gray_fifo
package async_fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  // Helpers work on a 32-bit container; callers size-cast to their own pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// rtl/gray_ptr_sync.sv - multi-flop synchroniser for a gray-coded pointer into another clock domain
module gray_ptr_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/async_gray_fifo.sv
// rtl/async_gray_fifo.sv - dual-clock FIFO, gray pointers, registered almost flags
// ASYNC_FIFO_ERR_EN adds sticky wr_overflow / rd_underflow outputs.
module async_gray_fifo
  import async_fifo_pkg::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6,
  parameter int AE_THRESH   = 1
) (
  input  logic          wclk,
  input  logic          reset_w,
  input  logic          rclk,
  input  logic          reset_r,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  output logic          full,
  output logic          almost_full,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          almost_empty
`ifdef ASYNC_FIFO_ERR_EN
  ,
  output logic          wr_overflow,
  output logic          rd_underflow
`endif
);

  localparam int DEPTH  = 1 << AW;
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  typedef logic [AW:0] ptr_t;

  localparam ptr_t AF_T = ptr_t'(AF_THRESH);
  localparam ptr_t AE_T = ptr_t'(AE_THRESH);
  // Full when the write pointer is one lap ahead: top two gray bits inverted.
  localparam ptr_t FULL_MASK = ptr_t'(3) << (AW - 1);

  logic [DW-1:0] mem [DEPTH];

  ptr_t wbin, wgray, wbin_next, wgray_next, rsync, rsync_bin, wlevel_next;
  ptr_t rbin, rgray, rbin_next, rgray_next, wsync, wsync_bin, rlevel_next;
  logic wr_accept, rd_accept;
  logic full_next, almost_full_next, empty_next, almost_empty_next;

  gray_ptr_sync #(.W(AW + 1), .STAGES(SYNC_N)) u_rptr_sync (
    .clk   (wclk),
    .reset (reset_w),
    .d     (rgray),
    .q     (rsync)
  );

  gray_ptr_sync #(.W(AW + 1), .STAGES(SYNC_N)) u_wptr_sync (
    .clk   (rclk),
    .reset (reset_r),
    .d     (wgray),
    .q     (wsync)
  );

  // Write domain
  assign wr_accept        = push && !full;
  assign wbin_next        = wbin + ptr_t'(wr_accept);
  assign wgray_next       = ptr_t'(bin2gray(32'(wbin_next)));
  assign rsync_bin        = ptr_t'(gray2bin(32'(rsync)));
  assign wlevel_next      = wbin_next - rsync_bin;
  assign full_next        = (wgray_next == (rsync ^ FULL_MASK));
  assign almost_full_next = (wlevel_next >= AF_T);

  always_ff @(posedge wclk or posedge reset_w) begin
    if (reset_w) begin
      wbin        <= '0;
      wgray       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wgray       <= wgray_next;
      full        <= full_next;
      almost_full <= almost_full_next;
    end
  end

  always_ff @(posedge wclk) begin
    if (wr_accept) begin
      mem[wbin[AW-1:0]] <= wdata;
    end
  end

  // Read domain; rdata is show-ahead straight from the array
  assign rd_accept         = pop && !empty;
  assign rbin_next         = rbin + ptr_t'(rd_accept);
  assign rgray_next        = ptr_t'(bin2gray(32'(rbin_next)));
  assign wsync_bin         = ptr_t'(gray2bin(32'(wsync)));
  assign rlevel_next       = wsync_bin - rbin_next;
  assign empty_next        = (rgray_next == wsync);
  assign almost_empty_next = (rlevel_next <= AE_T);
  assign rdata             = mem[rbin[AW-1:0]];

  always_ff @(posedge rclk or posedge reset_r) begin
    if (reset_r) begin
      rbin         <= '0;
      rgray        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
    end else begin
      rbin         <= rbin_next;
      rgray        <= rgray_next;
      empty        <= empty_next;
      almost_empty <= almost_empty_next;
    end
  end

`ifdef ASYNC_FIFO_ERR_EN
  always_ff @(posedge wclk or posedge reset_w) begin
    if (reset_w) begin
      wr_overflow <= 1'b0;
    end else if (push && full) begin
      wr_overflow <= 1'b1;
    end
  end

  always_ff @(posedge rclk or posedge reset_r) begin
    if (reset_r) begin
      rd_underflow <= 1'b0;
    end else if (pop && empty) begin
      rd_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_async_gray_fifo.sv
// tb/tb_async_gray_fifo.sv - randomized queue-model bench for async_gray_fifo (ASYNC_FIFO_ERR_EN aware)
module tb_async_gray_fifo;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic       wclk, rclk, reset_w, reset_r, push, pop;
  logic [7:0] wdata, rdata;
  logic       full, almost_full, empty, almost_empty;
`ifdef ASYNC_FIFO_ERR_EN
  logic       wr_overflow, rd_underflow;
`endif

  async_gray_fifo dut (
    .wclk         (wclk),
    .reset_w      (reset_w),
    .rclk         (rclk),
    .reset_r      (reset_r),
    .push         (push),
    .wdata        (wdata),
    .full         (full),
    .almost_full  (almost_full),
    .pop          (pop),
    .rdata        (rdata),
    .empty        (empty),
    .almost_empty (almost_empty)
`ifdef ASYNC_FIFO_ERR_EN
    ,
    .wr_overflow  (wr_overflow),
    .rd_underflow (rd_underflow)
`endif
  );

  int rhalf = 85;
  initial begin
    wclk = 1'b0;
    #3;
    forever #50 wclk = ~wclk;
  end
  initial begin
    rclk = 1'b0;
    forever #(rhalf) rclk = ~rclk;
  end

  logic [7:0] q[$];
  int  n_chk = 0, n_pass = 0, total_push = 0;
  bit  chk_en = 1'b0, first_pop = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // Continuous safety checks: a non-empty view must show the true head; a not-full view needs a free slot.
  initial forever begin
    @(negedge rclk);
    if (chk_en && !empty)
      chk("rd_head", (q.size() > 0) ? int'(rdata) : -1, (q.size() > 0) ? int'(q[0]) : -2);
  end
  initial forever begin
    @(negedge wclk);
    if (chk_en && !full) chk("full_safe", int'(q.size() < DEPTH), 1);
  end

  task automatic wr(input bit p, input logic [7:0] d);
    bit acc;
    @(negedge wclk);
    push  = p;
    wdata = d;
    acc   = p && !full;
    @(posedge wclk);
    if (acc) begin
      q.push_back(d);
      total_push++;
    end
    #1 push = 1'b0;
  endtask

  task automatic rd(input bit p, output logic [7:0] got, output bit acc);
    @(negedge rclk);
    pop = p;
    acc = p && !empty;
    got = rdata;
    @(posedge rclk);
    if (acc) void'(q.pop_front());
    #1 pop = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(posedge wclk);
    repeat (8) @(posedge rclk);
    #1;
  endtask

  // Once both sides have synchronised, every flag is exact for the model level.
  task automatic qcheck(input string tag);
    int n;
    n = q.size();
    chk({tag, "_full"}, int'(full), int'(n == DEPTH));
    chk({tag, "_empty"}, int'(empty), int'(n == 0));
    chk({tag, "_af"}, int'(almost_full), int'(n >= AF));
    chk({tag, "_ae"}, int'(almost_empty), int'(n <= AE));
  endtask

  task automatic do_reset();
    chk_en  = 1'b0;
    reset_w = 1'b1;
    reset_r = 1'b1;
    q.delete();
    repeat (3) @(posedge wclk);
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_ae", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
`ifdef ASYNC_FIFO_ERR_EN
    chk("rst_ovf", int'(wr_overflow), 0);
    chk("rst_udf", int'(rd_underflow), 0);
`endif
    @(negedge wclk) reset_w = 1'b0;
    @(negedge rclk) reset_r = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic rand_phase(input int rh, input int wcyc, input int rcyc);
    rhalf = rh;
    fork
      begin
        repeat (wcyc) wr(1'($urandom_range(0, 1)), 8'($urandom));
      end
      begin
        logic [7:0] g;
        bit a;
        repeat (rcyc) rd(1'($urandom_range(0, 1)), g, a);
      end
    join
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    bit acc;
    int n, tries;
    push = 1'b0; pop = 1'b0; wdata = '0;
    do_reset();

    // Fill without pops
    for (int i = 0; i < 8; i++) begin
      wr(1'b1, 8'(i));
      chk("fill_af", int'(almost_full), int'(i + 1 >= 6));
      chk("fill_full", int'(full), int'(i == 7));
    end
`ifdef ASYNC_FIFO_ERR_EN
    chk("ovf_before", int'(wr_overflow), 0);
`endif
    wr(1'b1, 8'hAA);
    chk("ninth_full", int'(full), 1);
`ifdef ASYNC_FIFO_ERR_EN
    chk("ovf_set", int'(wr_overflow), 1);
`endif

    // Drain; full must release within three wclk edges of the first pop
    fork
      begin
        int i;
        i = 0; tries = 0;
        while (i < 8 && tries < 200) begin
          rd(1'b1, got, acc);
          tries++;
          if (acc) begin
            chk("drain_data", int'(got), i);
            i++;
            first_pop = 1'b1;
          end
        end
        chk("drain_count", i, 8);
        chk("drain_empty", int'(empty), 1);
        first_pop = 1'b1;
      end
      begin
        wait (first_pop);
        n = 0;
        while (full && n < 6) begin
          @(posedge wclk);
          #1;
          n++;
        end
        chk_rng("full_release_edges", n, 2, 3);
      end
    join

    rd(1'b1, got, acc);
    chk("pop_empty_ignored", int'(acc), 0);
`ifdef ASYNC_FIFO_ERR_EN
    chk("udf_set", int'(rd_underflow), 1);
`endif
    settle();
    qcheck("drained");

    // Latency into an empty FIFO
    wr(1'b1, 8'h5C);
    n = 0;
    while (empty && n < 8) begin
      @(posedge rclk);
      #1;
      n++;
    end
    chk_rng("empty_latency", n, 2, 3);
    settle();
    qcheck("one");
    chk("one_ae", int'(almost_empty), 1);
    rd(1'b1, got, acc);
    chk("one_data", int'(got), 8'h5C);

    for (int i = 0; i < 3; i++) wr(1'b1, 8'(8'h10 + i));
    settle();
    chk("three_ae", int'(almost_empty), 0);
    chk("three_af", int'(almost_full), 0);
    qcheck("three");

    // Random traffic at 3:1 and 1:3 clock ratios
    rand_phase(150, 60, 20);
    settle();
    qcheck("r31");
    rand_phase(15, 60, 200);
    settle();
    qcheck("r13");
    rand_phase(85, 80, 47);
    rhalf = 85;
    tries = 0;
    while (q.size() > 0 && tries < 300) begin
      rd(1'b1, got, acc);
      tries++;
    end
    settle();
    qcheck("final");
    chk_rng("accepted_pushes", total_push, 17, 100000);

`ifdef ASYNC_FIFO_ERR_EN
    chk("ovf_hold", int'(wr_overflow), 1);
    chk("udf_hold", int'(rd_underflow), 1);
`endif
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
